// File: rtl/async_reg_bank_pkg.sv
// Shared helpers for the emulated asynchronous register bank.
// Edge polarity is folded into a single "active level" view of each strobe.
package async_reg_bank_pkg;

  // Maps a raw strobe level onto its active level for the given polarity.
  function automatic logic active_level(input logic c, input logic fall);
    return c ^ fall;
  endfunction

endpackage

// File: rtl/async_reg_chan.sv
// One WIDTH-bit emulated register channel, clocked by the falling edge of clock.
// Strobe edges are detected in the clock domain, with combinational set/reset overrides.
module async_reg_chan
  import async_reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               FALL      = 1'b0,
  parameter bit               LATCH     = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic             wr_pulse
);

  logic             r_c_d;
  logic [WIDTH-1:0] r_val;
  logic             r_wr_pulse;

  logic             w_act;
  logic             w_act_d;
  logic             w_open_edge;
  logic             w_close_edge;
  logic [WIDTH-1:0] w_base;

  assign w_act        = active_level(c, FALL);
  assign w_act_d      = active_level(r_c_d, FALL);
  assign w_open_edge  = w_act & ~w_act_d;
  assign w_close_edge = ~w_act & w_act_d;

  // Reset beats set, set beats the stored or transparent value.
  assign w_base   = (LATCH && w_act) ? d : r_val;
  assign q        = ~r & (s | w_base);
  assign wr_pulse = r_wr_pulse;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_val      <= RESET_VAL;
      r_wr_pulse <= 1'b0;
      r_c_d      <= c;
    end else begin
      r_c_d <= c;
      if (LATCH) begin
        r_val      <= q;
        r_wr_pulse <= w_close_edge;
      end else if (w_open_edge) begin
        r_val      <= d;
        r_wr_pulse <= 1'b1;
      end else begin
        // Folding q back in makes set/reset pulses persistent.
        r_val      <= q;
        r_wr_pulse <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/async_reg_bank.sv
// Bank of CHANNELS independent emulated registers with per-channel edge/latch mode.
// All channel vectors are packed, channel n occupying [n*WIDTH +: WIDTH].
module async_reg_bank #(
  parameter int                  WIDTH      = 8,
  parameter int                  CHANNELS   = 4,
  parameter logic [WIDTH-1:0]    RESET_VAL  = '0,
  parameter logic [CHANNELS-1:0] FALL_MASK  = '0,
  parameter logic [CHANNELS-1:0] LATCH_MASK = '0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       c,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS*WIDTH-1:0] s,
  input  logic [CHANNELS*WIDTH-1:0] r,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       wr_pulse
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    async_reg_chan #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL),
      .FALL     (FALL_MASK[n]),
      .LATCH    (LATCH_MASK[n])
    ) u_chan (
      .clock   (clock),
      .reset   (reset),
      .c       (c[n]),
      .d       (d[n*WIDTH +: WIDTH]),
      .s       (s[n*WIDTH +: WIDTH]),
      .r       (r[n*WIDTH +: WIDTH]),
      .q       (q[n*WIDTH +: WIDTH]),
      .wr_pulse(wr_pulse[n])
    );
  end

endmodule
